// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared opcodes, FSM states and command layout for the FPU front end
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    // The tag sits above this struct in the FIFO word: {tag, sel, b, a}
    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] b;
        logic [31:0] a;
    } cmd_op_t;

    localparam int c_CMD_OP_W = $bits(cmd_op_t);

endpackage
`default_nettype wire

// File: rtl/fpu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpu_cmd_fifo
// Purpose  : Parameterised synchronous FIFO with full/empty flags and count
// Revision : 1.0 - initial release
// ============================================================================
module fpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_CNT = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses a push even when a pop frees a slot on the same edge
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == c_FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_ctrl
// Purpose  : Buffers tagged FP ALU commands, sequences the ALU, returns results
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             control,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [1:0]       cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [1:0]       alu_select,
    input  logic [31:0]      alu_out,
    input  logic             alu_exception,
    input  logic             alu_zeroDiv,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_exception,
    output logic             res_zeroDiv,
    output logic             sticky_exc,
    output logic             sticky_zdiv,
    input  logic             clr_sticky,
    output logic             busy
);

    localparam int c_WORD_W = TAG_W + c_CMD_OP_W;
    localparam int c_CNT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ALU_LAT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [31:0]          r_alu_a;
    logic [31:0]          r_alu_b;
    logic [1:0]           r_alu_sel;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_res_valid;
    logic [31:0]          r_res_data;
    logic [TAG_W-1:0]     r_res_tag;
    logic                 r_res_exc;
    logic                 r_res_zdiv;
    logic                 r_sticky_exc;
    logic                 r_sticky_zdiv;

    logic                 w_pop;
    logic                 w_capture;
    logic                 w_res_take;
    logic                 w_full;
    logic                 w_empty;
    logic [c_WORD_W-1:0]  w_head;
    logic [$clog2(DEPTH):0] w_count;
    cmd_op_t              w_head_op;
    logic [TAG_W-1:0]     w_head_tag;

    fpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_WORD_W)
    ) u_fifo (
        .clk     (control),
        .rst_n   (reset),
        .i_push  (cmd_valid),
        .i_data  ({cmd_tag, cmd_sel, cmd_b, cmd_a}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_op  = cmd_op_t'(w_head[c_CMD_OP_W-1:0]);
    assign w_head_tag = w_head[c_WORD_W-1:c_CMD_OP_W];

    always_ff @(posedge control or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_res_take  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    w_res_take = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge control or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_sel     <= '0;
            r_tag         <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_tag     <= '0;
            r_res_exc     <= 1'b0;
            r_res_zdiv    <= 1'b0;
            r_sticky_exc  <= 1'b0;
            r_sticky_zdiv <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_a   <= w_head_op.a;
                r_alu_b   <= w_head_op.b;
                r_alu_sel <= w_head_op.sel;
                r_tag     <= w_head_tag;
                r_cnt     <= c_CNT_LOAD;
            end else if (r_state == ST_RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture) begin
                r_res_data <= alu_out;
                r_res_tag  <= r_tag;
                r_res_exc  <= alu_exception;
                r_res_zdiv <= alu_zeroDiv;
            end

            if (w_capture) begin
                r_res_valid <= 1'b1;
            end else if (w_res_take) begin
                r_res_valid <= 1'b0;
            end

            // A capture that sets a flag outranks a clear on the same edge
            r_sticky_exc  <= (r_sticky_exc  & ~clr_sticky) | (w_capture & alu_exception);
            r_sticky_zdiv <= (r_sticky_zdiv & ~clr_sticky) | (w_capture & alu_zeroDiv);
        end
    end

    assign cmd_ready     = !w_full;
    assign busy          = (w_count != '0) || (r_state != ST_IDLE);
    assign alu_A         = r_alu_a;
    assign alu_B         = r_alu_b;
    assign alu_select    = r_alu_sel;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_tag       = r_res_tag;
    assign res_exception = r_res_exc;
    assign res_zeroDiv   = r_res_zdiv;
    assign sticky_exc    = r_sticky_exc;
    assign sticky_zdiv   = r_sticky_zdiv;

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_ctrl
// Purpose  : Scoreboard bench for fpu_issue_ctrl with a latency-accurate ALU stub
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_ctrl;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 2;
    localparam int TAG_W   = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [31:0] r;
        logic        exc;
        logic        zdiv;
    } vec_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             exc;
        logic             zdiv;
    } exp_t;

    // Hand-computed single-precision results
    function automatic vec_t get_vec(input int i);
        vec_t v;
        case (i)
            0: v = '{32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 1'b0, 1'b0}; // 1+2=3
            1: v = '{32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000, 1'b0, 1'b1}; // 1/0
            2: v = '{32'hBF800000, 32'h40000000, 2'b10, 32'hC0000000, 1'b0, 1'b0}; // -1*2=-2
            3: v = '{32'h3F800000, 32'hC0000000, 2'b01, 32'h40400000, 1'b0, 1'b0}; // 1-(-2)=3
            4: v = '{32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 1'b0, 1'b0}; // 2*3=6
            5: v = '{32'h40800000, 32'h40000000, 2'b11, 32'h40000000, 1'b0, 1'b0}; // 4/2=2
            6: v = '{32'h7F800000, 32'h7F800000, 2'b00, 32'h7F800000, 1'b1, 1'b0}; // inf+inf
            default: v = '{32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 1'b0, 1'b0}; // 3-1=2
        endcase
        return v;
    endfunction

    logic             control = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_a = '0;
    logic [31:0]      cmd_b = '0;
    logic [1:0]       cmd_sel = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [31:0]      alu_A;
    logic [31:0]      alu_B;
    logic [1:0]       alu_select;
    logic [31:0]      alu_out;
    logic             alu_exception;
    logic             alu_zeroDiv;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_exception;
    logic             res_zeroDiv;
    logic             sticky_exc;
    logic             sticky_zdiv;
    logic             clr_sticky = 1'b0;
    logic             busy;

    logic fixed_rr = 1'b0;
    logic rand_mode = 1'b0;
    logic rnd_rr = 1'b0;
    assign res_ready = rand_mode ? rnd_rr : fixed_rr;

    fpu_issue_ctrl #(
        .DEPTH   (DEPTH),
        .ALU_LAT (ALU_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .control       (control),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_sel       (cmd_sel),
        .cmd_tag       (cmd_tag),
        .alu_A         (alu_A),
        .alu_B         (alu_B),
        .alu_select    (alu_select),
        .alu_out       (alu_out),
        .alu_exception (alu_exception),
        .alu_zeroDiv   (alu_zeroDiv),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .res_exception (res_exception),
        .res_zeroDiv   (res_zeroDiv),
        .sticky_exc    (sticky_exc),
        .sticky_zdiv   (sticky_zdiv),
        .clr_sticky    (clr_sticky),
        .busy          (busy)
    );

    always #5 control = ~control;

    int cyc = 0;
    always @(posedge control) cyc <= cyc + 1;

    initial forever begin
        @(posedge control);
        #1;
        rnd_rr = 1'($urandom_range(0, 1));
    end

    // ALU stub: result valid only after operands have been held ALU_LAT cycles
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [1:0]  d_sel;
    always @(posedge control) begin
        d_a   <= alu_A;
        d_b   <= alu_B;
        d_sel <= alu_select;
    end

    always_comb begin
        alu_out       = 32'hBAD0BAD0;
        alu_exception = 1'b0;
        alu_zeroDiv   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (get_vec(i).a == d_a && get_vec(i).b == d_b && get_vec(i).sel == d_sel) begin
                alu_out       = get_vec(i).r;
                alu_exception = get_vec(i).exc;
                alu_zeroDiv   = get_vec(i).zdiv;
            end
        end
    end

    int   n_chk = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   cur_idx = 0;
    exp_t sb[$];
    int   hs_times[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept side: record the expected response of every accepted command
    always @(negedge control) begin
        if (reset && cmd_valid && cmd_ready) begin
            sb.push_back('{cmd_tag, get_vec(cur_idx).r, get_vec(cur_idx).exc, get_vec(cur_idx).zdiv});
            n_acc++;
        end
    end

    // Result side: a presented result must match the head of the scoreboard
    always @(negedge control) begin
        if (reset && res_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_result: got tag %0h data %0h with nothing outstanding", res_tag, res_data);
            end else begin
                chk("result", {res_tag, res_data, res_exception, res_zeroDiv}, sb[0]);
                if (res_ready) begin
                    void'(sb.pop_front());
                    hs_times.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge control);
        #1;
    endtask

    task automatic drive(input int idx, input int tag);
        cur_idx   = idx;
        cmd_a     = get_vec(idx).a;
        cmd_b     = get_vec(idx).b;
        cmd_sel   = get_vec(idx).sel;
        cmd_tag   = TAG_W'(tag);
        cmd_valid = 1'b1;
    endtask

    task automatic send(input int idx, input int tag);
        logic got;
        got = 1'b0;
        drive(idx, tag);
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge control);
            got = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("send_accept", got, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 300) begin
            tick();
            t++;
        end
        chk("idle_reached", {63'd0, (sb.size() == 0 && !busy)}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        // Reset state
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu", {alu_A, alu_B, alu_select}, 0);
        chk("rst_res", {res_data, res_tag, res_exception, res_zeroDiv, sticky_exc, sticky_zdiv}, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Single add: res_valid exactly ALU_LAT+1 cycles after acceptance
        fixed_rr = 1'b1;
        send(0, 5);
        chk("busy_after_accept", busy, 1);
        tick();
        chk("add_valid_k1", res_valid, 0);
        tick();
        chk("add_valid_k2", res_valid, 0);
        tick();
        chk("add_valid_k3", res_valid, 1);
        wait_idle();

        // Zero division and sticky behaviour
        send(1, 1);
        wait_idle();
        chk("zdiv_res", res_zeroDiv, 1);
        chk("zdiv_sticky", sticky_zdiv, 1);
        send(4, 2);
        wait_idle();
        chk("mul_res_zdiv", res_zeroDiv, 0);
        chk("zdiv_sticky_held", sticky_zdiv, 1);
        chk("mul_res_data", res_data, 32'h40C00000);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("zdiv_sticky_cleared", sticky_zdiv, 0);
        send(1, 3);
        tick();
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("set_beats_clear", sticky_zdiv, 1);
        chk("sticky_exc_clean", sticky_exc, 0);
        wait_idle();

        // Back-pressure and fill
        fixed_rr = 1'b0;
        acc0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            drive(i, i);
            tick();
        end
        cmd_valid = 1'b0;
        chk("fill_accepted", 64'(n_acc - acc0), 5);
        chk("fill_cmd_ready", cmd_ready, 0);
        chk("fill_busy", busy, 1);
        chk("fill_res_valid", res_valid, 1);
        hs_times.delete();
        fixed_rr = 1'b1;
        tick();
        chk("ready_after_pop", cmd_ready, 1);
        wait_idle();
        chk("drain_count", 64'(hs_times.size()), 5);
        for (int i = 1; i < hs_times.size(); i++) begin
            chk("result_spacing", 64'(hs_times[i] - hs_times[i-1]), ALU_LAT + 1);
        end

        // Pointer wrap with random valid/ready
        rand_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(i % 8, i);
        end
        for (int t = 0; t < 400 && (sb.size() != 0 || busy); t++) tick();
        rand_mode = 1'b0;
        chk("wrap_drained", 64'(sb.size()), 0);
        wait_idle();

        // Reset in the middle of RUN with two commands queued
        for (int i = 0; i < 3; i++) begin
            drive(2 + i, 8 + i);
            tick();
        end
        cmd_valid = 1'b0;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_alu", {alu_A, alu_B, alu_select}, 0);
        chk("mid_rst_res", {res_data, res_tag, res_exception, res_zeroDiv, sticky_exc, sticky_zdiv}, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (12) tick();
        chk("post_rst_no_result", res_valid, 0);
        chk("post_rst_idle", busy, 0);

        // Exception capture
        chk("exc_sticky_before", sticky_exc, 0);
        send(6, 7);
        wait_idle();
        chk("exc_res", res_exception, 1);
        chk("exc_sticky", sticky_exc, 1);
        chk("exc_data", res_data, 32'h7F800000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Command front end for the 32-bit floating-point ALU (`ALU_top`). It accepts tagged operation requests over a valid/ready interface and buffers them in a small FIFO. It drives `A`/`B`/`select` into the ALU, holds them stable for a fixed settle time, then captures `out`/`exception`/`zeroDiv` into a result register returned over a second valid/ready interface. Sticky exception flags accumulate across operations until software clears them.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ALU_LAT`, 2: cycles the ALU inputs are held before its outputs are sampled; ≥1.
- `TAG_W`, 4: width of the request tag carried through to the result.

Ports:
- `control`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: request present.
- `cmd_ready`, out, 1: request accepted this cycle if `cmd_valid`.
- `cmd_a`, `cmd_b`, in, 32: IEEE-754 single operands.
- `cmd_sel`, in, 2: 00 add, 01 sub, 10 mul, 11 div.
- `cmd_tag`, in, TAG_W: opaque request tag.
- `alu_A`, `alu_B`, out, 32: to ALU `A`/`B`.
- `alu_select`, out, 2: to ALU `select`.
- `alu_out`, in, 32: from ALU `out`.
- `alu_exception`, `alu_zeroDiv`, in, 1: from ALU flags.
- `res_valid`, out, 1: result register holds an unconsumed result.
- `res_ready`, in, 1: consumer takes the result.
- `res_data`, out, 32: captured `alu_out`.
- `res_tag`, out, TAG_W: tag of the captured operation.
- `res_exception`, `res_zeroDiv`, out, 1: captured flags.
- `sticky_exc`, `sticky_zdiv`, out, 1: OR of all captured flags since last clear.
- `clr_sticky`, in, 1: synchronous clear of both sticky flags.
- `busy`, out, 1: FIFO non-empty or state ≠ IDLE.

## Operation
- **FIFO push:** push on `cmd_valid && cmd_ready`. `cmd_ready = !full`; it is registered from the FIFO count, with no combinational path from `res_ready`. On a full FIFO no push occurs, even if a pop happens in the same cycle.
- **Pointers:** log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- **FSM states:** IDLE, RUN, RESULT.
  - **IDLE:** if the FIFO is non-empty, pop the head into `alu_A`/`alu_B`/`alu_select` and the internal tag register, load `cnt = ALU_LAT-1`, and go to RUN.
  - **RUN:** operands are held constant. If `cnt == 0`, capture `alu_out`, `alu_exception`, `alu_zeroDiv` and the tag into the `res_*` registers, set `res_valid`, and go to RESULT. Otherwise decrement `cnt`.
  - **RESULT:** wait for `res_ready`. On the handshake edge, clear `res_valid`. If the FIFO is non-empty, pop the next entry and go directly to RUN (same load as IDLE); otherwise go to IDLE.
- **Same-cycle push and pop:** an entry pushed on the same edge as a pop of an empty FIFO is not visible to the pop. It is first poppable on the next edge.
- **Holding outputs:** `alu_*` outputs keep their last value in IDLE. `res_*` outputs keep their values after the handshake until the next capture.
- **Sticky flags:** set on capture when the captured flag is 1. If a set and `clr_sticky` happen on the same edge, the set wins.
- **Flag pass-through:** no arithmetic is performed here. Flags are passed through, not recomputed.
- **Reset:** while `reset` = 0, FIFO is empty, state is IDLE, `cnt` = 0.
  - All outputs are 0, except `cmd_ready`, which is 1.
  - An in-flight operation and any buffered commands are discarded.

## Timing
- Command accepted at edge k → operands on `alu_*` after edge k+1 → capture at edge k+1+ALU_LAT.
- `res_valid` is high from k+1+ALU_LAT, i.e. ALU_LAT+1 cycles after acceptance.
- Back-to-back throughput with `res_ready` held high: one result every ALU_LAT+1 cycles.
- Maximum occupancy with `res_ready` low: one operation in RESULT plus DEPTH queued. `cmd_ready` falls the cycle after the DEPTH-th queued push.
- `res_valid` never drops without a handshake. `res_data`/`res_tag` are stable while `res_valid && !res_ready`.

## Structure
- Shared package `fpu_pkg`:
  - Opcode constants `OP_ADD`=2'b00, `OP_SUB`, `OP_MUL`, `OP_DIV`.
  - FSM state enumeration.
  - Command struct layout {tag, sel, b, a}.
- Sub-module `fpu_cmd_fifo`: a parameterised synchronous FIFO with push, pop, full, empty and count. The FSM, counter and result/sticky registers live in `fpu_issue_ctrl`.

## Test plan
- **Single add:** ALU_LAT=2, reset released, push a=3F800000, b=40000000, sel=00, tag=5, `res_ready`=1 → `res_valid` 3 cycles after accept; `res_data`=40400000, `res_tag`=5, both flags 0.
- **Zero division:** push 3F800000 / 00000000, sel=11 → `res_zeroDiv`=1 and `sticky_zdiv`=1. `sticky_zdiv` stays 1 across a following clean multiply; pulsing `clr_sticky` clears it. A `clr_sticky` on the capture edge of another divide-by-zero leaves it at 1.
- **Back-pressure and fill:** `res_ready`=0, push 6 commands back-to-back → 5 accepted, `cmd_ready` low after the 5th. Then raise `res_ready` → tags 0..4 returned in order at ALU_LAT+1-cycle spacing. `cmd_ready` reasserts after the first pop.
- **Pointer wrap:** stream 10 mixed ops (−1.0 × 2.0 = C0000000, 1.0 − (−2.0) = 40400000, …) with random `cmd_valid`/`res_ready` → results match the reference model in tag order; no loss or duplication.
- **Reset mid-RUN:** assert `reset`=0 during RUN with 2 entries queued → all outputs 0, `cmd_ready`=1, `busy`=0 immediately (asynchronous). After release, no stale result appears.
- **Exception capture:** push 7F800000 + 7F800000 → `res_exception` equals the ALU's flag, and `sticky_exc` is set if that flag is 1.
